// File: rtl/inst_fetcher_pkg.sv
// Shared constants and helpers for the fetch front end and the decoder.
package inst_fetcher_pkg;

  localparam int          INST_W     = 32;
  localparam logic [6:0]  OPCODE_JAL = 7'b1101111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  // One instruction-queue entry: 3 x 32 = 96 bits.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] pred_pc;
  } iq_entry_t;

  // Sign-extended J-type immediate (byte offset, bit 0 always zero).
  function automatic logic [INST_W-1:0] j_imm(input logic [INST_W-1:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// inst_queue: synchronous FIFO of decoded-ready fetch entries with
// push, pop, clear and occupancy count. Everything freezes while en_in is low.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             clear_in,
  input  logic             push_in,
  input  iq_entry_t        push_data,
  input  logic             pop_in,
  output logic             head_valid,
  output iq_entry_t        head_data,
  output logic [CNT_W-1:0] count
);

  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Pointer and occupancy update; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (en_in) begin
      if (clear_in) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push_in) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_in)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_in) - CNT_W'(pop_in);
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observable through a valid head.
  always_ff @(posedge clk_in) begin
    if (en_in && !clear_in && push_in) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: one outstanding word request, static JAL
// prediction, and a small queue of {inst, pc, pred_pc} for the decoder.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no request outstanding (queue full or just out of reset)
//   S_FETCH | start_fetch=1, pc held stable until a matching word returns
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] rob_new_pc,
  output logic [31:0] pc,
  output logic        start_fetch,
  input  logic        fetch_ready,
  input  logic [31:0] inst,
  input  logic [31:0] inst_addr,
  input  logic        dec_ready,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_pred_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pred_pc;
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] iq_count;
  logic [CNT_W-1:0] count_next;
  iq_entry_t        push_entry;
  iq_entry_t        head_entry;

  // Static predictor and handshake qualification; flush discards both sides.
  always_comb begin
    pred_pc    = fetch_pc_q + ((inst[6:0] == OPCODE_JAL) ? j_imm(inst) : 32'd4);
    accept     = rdy_in && !rob_clear_up && (state_q == S_FETCH) &&
                 fetch_ready && (inst_addr == fetch_pc_q);
    pop        = rdy_in && !rob_clear_up && iq_valid && dec_ready;
    count_next = iq_count + CNT_W'(accept) - CNT_W'(pop);
    push_entry = '{inst: inst, pc: fetch_pc_q, pred_pc: pred_pc};
  end

  // Next-state and fetch PC; flush has top priority, rdy_in low freezes all.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (rdy_in) begin
      if (rob_clear_up) begin
        state_d    = S_FETCH;
        fetch_pc_d = rob_new_pc;
      end else begin
        case (state_q)
          S_FETCH: begin
            if (accept) begin
              fetch_pc_d = pred_pc;
              state_d    = (count_next < CNT_W'(DEPTH)) ? S_FETCH : S_IDLE;
            end
          end
          default: begin
            if (iq_count < CNT_W'(DEPTH)) state_d = S_FETCH;
          end
        endcase
      end
    end
  end

  // State and fetch PC registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  inst_queue #(.DEPTH(DEPTH)) u_inst_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en_in      (rdy_in),
    .clear_in   (rob_clear_up),
    .push_in    (accept),
    .push_data  (push_entry),
    .pop_in     (pop),
    .head_valid (iq_valid),
    .head_data  (head_entry),
    .count      (iq_count)
  );

  assign pc          = fetch_pc_q;
  assign start_fetch = (state_q == S_FETCH);
  assign iq_inst     = head_entry.inst;
  assign iq_pc       = head_entry.pc;
  assign iq_pred_pc  = head_entry.pred_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference.
module tb_inst_fetcher;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear_up, fetch_ready, dec_ready;
  logic [31:0] rob_new_pc, inst, inst_addr;
  logic [31:0] pc, iq_inst, iq_pc, iq_pred_pc;
  logic        start_fetch, iq_valid;

  always #5 clk_in = ~clk_in;

  inst_fetcher #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .rob_clear_up (rob_clear_up),
    .rob_new_pc   (rob_new_pc),
    .pc           (pc),
    .start_fetch  (start_fetch),
    .fetch_ready  (fetch_ready),
    .inst         (inst),
    .inst_addr    (inst_addr),
    .dec_ready    (dec_ready),
    .iq_valid     (iq_valid),
    .iq_inst      (iq_inst),
    .iq_pc        (iq_pc),
    .iq_pred_pc   (iq_pred_pc)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] at;
    logic [31:0] nxt;
  } ent_t;

  ent_t        m_q[$];
  bit          m_req;
  logic [31:0] m_pc;

  // Next PC from the prediction rule, using plain offset arithmetic.
  function automatic logic [31:0] ref_pred(input logic [31:0] w, input logic [31:0] at);
    logic [31:0] off;
    if (w[6:0] != 7'h6F) return at + 32'd4;
    off = {11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0};
    if (w[31]) off = off - 32'h0020_0000;
    return at + off;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour at one clock edge, from the inputs currently driven.
  task automatic model_update();
    int old_n;
    bit acc, pp;
    ent_t e;
    if (rst_in) begin
      m_req = 1'b0;
      m_pc  = RESET_PC;
      m_q.delete();
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        m_q.delete();
        m_pc  = rob_new_pc;
        m_req = 1'b1;
      end else begin
        old_n = m_q.size();
        acc = m_req && fetch_ready && (inst_addr == m_pc);
        pp  = (old_n > 0) && dec_ready;
        if (pp) void'(m_q.pop_front());
        if (acc) begin
          e.w = inst; e.at = m_pc; e.nxt = ref_pred(inst, m_pc);
          m_q.push_back(e);
          m_pc  = e.nxt;
          m_req = (m_q.size() < DEPTH);
        end else if (!m_req) begin
          m_req = (old_n < DEPTH);
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("start_fetch", {31'd0, start_fetch}, {31'd0, m_req});
    chk("pc", pc, m_pc);
    chk("iq_valid", {31'd0, iq_valid}, {31'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      chk("iq_inst", iq_inst, m_q[0].w);
      chk("iq_pc", iq_pc, m_q[0].at);
      chk("iq_pred_pc", iq_pred_pc, m_q[0].nxt);
    end else begin
      chk("iq_inst_empty", iq_inst, 32'd0);
      chk("iq_pc_empty", iq_pc, 32'd0);
      chk("iq_pred_pc_empty", iq_pred_pc, 32'd0);
    end
  endtask

  task automatic step(input bit r, input bit rd, input bit cl, input logic [31:0] np,
                      input bit fr, input logic [31:0] w, input logic [31:0] a,
                      input bit dr);
    rst_in = r; rdy_in = rd; rob_clear_up = cl; rob_new_pc = np;
    fetch_ready = fr; inst = w; inst_addr = a; dec_ready = dr;
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic idle();
    step(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] rv, w, a, np;
    bit r, rd, cl, fr, dr;

    rst_in = 1; rdy_in = 1; rob_clear_up = 0; rob_new_pc = 0;
    fetch_ready = 0; inst = 0; inst_addr = 0; dec_ready = 0;
    m_req = 0; m_pc = RESET_PC;

    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_start_fetch", {31'd0, start_fetch}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_iq_valid", {31'd0, iq_valid}, 32'd0);
    chk("rst_iq_pc", iq_pc, 32'h0);

    idle();
    chk("first_req", {31'd0, start_fetch}, 32'd1);
    chk("first_pc", pc, 32'h0);

    step(0, 1, 0, 0, 1, 32'h0000_0013, 32'h0, 0);
    chk("nop_iq_pc", iq_pc, 32'h0);
    chk("nop_iq_pred", iq_pred_pc, 32'h4);
    chk("nop_next_pc", pc, 32'h4);
    chk("nop_req", {31'd0, start_fetch}, 32'd1);

    step(0, 1, 1, 32'h10, 0, 0, 0, 0);
    chk("flush_empty", {31'd0, iq_valid}, 32'd0);
    step(0, 1, 0, 0, 1, 32'h0100_006F, 32'h10, 0);
    chk("jal_fwd_pred", iq_pred_pc, 32'h20);
    chk("jal_fwd_pc", pc, 32'h20);
    step(0, 1, 1, 32'h10, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'hFF1F_F06F, 32'h10, 0);
    chk("jal_back_pred", iq_pred_pc, 32'h0);
    chk("jal_back_pc", pc, 32'h0);

    step(0, 1, 1, 32'h0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1, 32'h13, 32'(4 * k), 0);
    chk("full_count", 32'(m_q.size()), 32'd4);
    chk("full_req", {31'd0, start_fetch}, 32'd0);
    chk("full_pc", pc, 32'h10);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    chk("pop_head", iq_pc, 32'h4);
    idle();
    chk("refetch_req", {31'd0, start_fetch}, 32'd1);
    chk("refetch_pc", pc, 32'h10);

    step(0, 1, 1, 32'h80, 1, 32'h13, 32'h10, 1);
    chk("flush_valid", {31'd0, iq_valid}, 32'd0);
    chk("flush_pc", pc, 32'h80);
    chk("flush_req", {31'd0, start_fetch}, 32'd1);
    idle();
    idle();
    chk("flush_no_ghost", {31'd0, iq_valid}, 32'd0);

    step(0, 1, 0, 0, 1, 32'h13, 32'h80, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, (k == 1), 32'h200, 1, 32'h13, 32'h84, 1);
      chk("frz_pc", pc, 32'h84);
      chk("frz_head", iq_pc, 32'h80);
    end
    step(0, 1, 0, 0, 1, 32'h13, 32'h84, 1);
    chk("resume_head", iq_pc, 32'h84);
    chk("resume_pc", pc, 32'h88);

    step(0, 1, 0, 0, 1, 32'h6F, 32'h90, 0);
    chk("mismatch_pc", pc, 32'h88);
    chk("mismatch_req", {31'd0, start_fetch}, 32'd1);
    chk("mismatch_head", iq_pc, 32'h84);

    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom % 700) == 0;
      rd = ($urandom % 8) != 0;
      cl = ($urandom % 30) == 0;
      rv = $urandom;
      np = {rv[31:2], 2'b00};
      fr = m_req ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      a  = (($urandom % 5) == 0) ? (m_pc ^ 32'h4) : m_pc;
      w  = $urandom;
      if (($urandom % 3) == 0) w[6:0] = 7'h6F;
      dr = ((i / 200) % 2) != 0 ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      step(r, rd, cl, np, fr, w, a, dr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
